// File: rtl/motor_ramp_ctrl_if.sv
// motor_ramp_ctrl_if: command, estop and motor-drive signals of the motion controller.
interface motor_ramp_ctrl_if;
    logic       cmd_valid_i;
    logic [1:0] cmd_mode_i;
    logic [9:0] cmd_speed_i;
    logic       estop_i;
    logic       cmd_ready_o;
    logic [1:0] mode_o;
    logic [9:0] speed_o;
    logic       busy_o;
    logic       at_target_o;

    modport slave (
        input  cmd_valid_i, cmd_mode_i, cmd_speed_i, estop_i,
        output cmd_ready_o, mode_o, speed_o, busy_o, at_target_o
    );

    modport master (
        output cmd_valid_i, cmd_mode_i, cmd_speed_i, estop_i,
        input  cmd_ready_o, mode_o, speed_o, busy_o, at_target_o
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: ramps motor speed toward a commanded target, braking and dwelling before reversal.
module motor_ramp_ctrl #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter logic [9:0]  STEP        = 10'd25,
    parameter int unsigned DWELL_TICKS = 50,
    parameter logic [9:0]  MAX_SPEED   = 10'd1000
) (
    input logic              clk,
    input logic              rst_n,
    motor_ramp_ctrl_if.slave bus
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW = DWELL_TICKS > 1 ? $clog2(DWELL_TICKS) : 1;

    typedef enum logic [2:0] {IDLE, RUN, BRAKE, DWELL, ESTOP} state_t;

    state_t        state_q;
    logic [1:0]    mode_q, req_q, req_d;
    logic [9:0]    speed_q, target_q, tgt_d, clamped, spd_run, spd_brk;
    logic [CW-1:0] tick_cnt_q;
    logic [DW-1:0] dwell_cnt_q;
    logic [10:0]   up, dn_floor;
    logic          ready, tick, cmd_acc, cmd_stop;

    assign ready = state_q != ESTOP && !bus.estop_i;
    assign tick  = tick_cnt_q == CW'(TICK_DIV - 1);

    always_comb begin
        cmd_acc  = bus.cmd_valid_i && ready;
        clamped  = bus.cmd_speed_i > MAX_SPEED ? MAX_SPEED : bus.cmd_speed_i;
        cmd_stop = bus.cmd_mode_i == 2'b00 || clamped == '0;
        req_d    = cmd_acc ? (cmd_stop ? 2'b00 : bus.cmd_mode_i) : req_q;
        tgt_d    = cmd_acc ? (cmd_stop ? '0 : clamped) : target_q;
        up       = {1'b0, speed_q} + {1'b0, STEP};
        dn_floor = {1'b0, tgt_d} + {1'b0, STEP};
        // saturating step toward the target, widened so neither direction can wrap
        spd_run  = !tick ? speed_q
                 : speed_q < tgt_d ? (up > {1'b0, tgt_d} ? tgt_d : up[9:0])
                 : ({1'b0, speed_q} < dn_floor ? tgt_d : speed_q - STEP);
        spd_brk  = !tick ? speed_q : speed_q < STEP ? '0 : speed_q - STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt_q <= '0;
        else
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            speed_q     <= '0;
            target_q    <= '0;
            req_q       <= 2'b00;
            dwell_cnt_q <= '0;
        end else if (bus.estop_i) begin
            state_q  <= ESTOP;
            mode_q   <= 2'b00;
            speed_q  <= '0;
            target_q <= '0;
            req_q    <= 2'b00;
        end else begin
            req_q    <= req_d;
            target_q <= tgt_d;
            case (state_q)
                IDLE: begin
                    if (req_d != 2'b00) begin
                        mode_q  <= req_d;
                        state_q <= RUN;
                    end
                end
                RUN, BRAKE: begin
                    if (req_d == mode_q) begin
                        speed_q <= spd_run;
                        state_q <= RUN;
                    end else begin
                        // stopping or reversing: drive speed to zero before releasing the bridge
                        speed_q <= spd_brk;
                        if (spd_brk == '0) begin
                            mode_q      <= 2'b00;
                            dwell_cnt_q <= '0;
                            state_q     <= req_d == 2'b00 ? IDLE : DWELL;
                        end else if (req_d != 2'b00) begin
                            state_q <= BRAKE;
                        end
                    end
                end
                DWELL: begin
                    if (req_d == 2'b00) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        if (dwell_cnt_q == DW'(DWELL_TICKS - 1)) begin
                            mode_q  <= req_d;
                            state_q <= RUN;
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q + DW'(1);
                        end
                    end
                end
                ESTOP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o = ready;
    assign bus.mode_o      = mode_q;
    assign bus.speed_o     = speed_q;
    assign bus.busy_o      = state_q == BRAKE || state_q == DWELL || speed_q != target_q;
    assign bus.at_target_o = speed_q == target_q && mode_q == req_q;
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed ramp/brake/dwell/estop/reset scenarios checked against a behavioural model.
module tb_motor_ramp_ctrl;
    localparam int TD = 4, ST = 50, DT = 2, MX = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0, passed = 0;

    motor_ramp_ctrl_if bus();

    motor_ramp_ctrl #(
        .TICK_DIV(TD), .STEP(10'd50), .DWELL_TICKS(DT), .MAX_SPEED(10'd1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: direction, speed, target, pending request, remaining dwell ticks, estop latch.
    int m_mode, m_speed, m_target, m_req, m_dwell, m_edges;
    bit m_halt;

    function automatic int approach(input int s, input int t);
        if (s < t) return (s + ST > t) ? t : s + ST;
        return (s - ST < t) ? t : s - ST;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit tick;
        int cs;
        if (!rst_n) begin
            m_mode = 0; m_speed = 0; m_target = 0; m_req = 0; m_dwell = 0; m_edges = 0; m_halt = 0;
        end else begin
            tick = (m_edges % TD) == TD - 1;
            m_edges++;
            if (bus.estop_i) begin
                m_mode = 0; m_speed = 0; m_target = 0; m_req = 0; m_dwell = 0; m_halt = 1;
            end else if (m_halt) begin
                m_halt = 0;
            end else begin
                if (bus.cmd_valid_i) begin
                    cs = bus.cmd_speed_i > MX ? MX : int'(bus.cmd_speed_i);
                    if (bus.cmd_mode_i == 0 || cs == 0) begin m_req = 0; m_target = 0; end
                    else begin m_req = bus.cmd_mode_i; m_target = cs; end
                end
                if (m_mode == 0 && m_dwell > 0) begin
                    if (m_req == 0) m_dwell = 0;
                    else if (tick) begin
                        m_dwell--;
                        if (m_dwell == 0) m_mode = m_req;
                    end
                end else if (m_mode == 0) begin
                    if (m_req != 0) m_mode = m_req;
                end else if (m_req == m_mode) begin
                    if (tick) m_speed = approach(m_speed, m_target);
                end else begin
                    if (tick) m_speed = approach(m_speed, 0);
                    if (m_speed == 0) begin
                        m_mode = 0;
                        if (m_req != 0) m_dwell = DT;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("mode", bus.mode_o, m_mode);
        chk("speed", bus.speed_o, m_speed);
        chk("cmd_ready", bus.cmd_ready_o, int'(!m_halt && !bus.estop_i));
        chk("busy", bus.busy_o, int'((m_mode == 0 && m_dwell > 0) ||
            (m_mode != 0 && m_req != 0 && m_req != m_mode) || m_speed != m_target));
        chk("at_target", bus.at_target_o, int'(m_speed == m_target && m_mode == m_req));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] m, input logic [9:0] s);
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_mode_i = m; bus.cmd_speed_i = s;
        step();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_for(input string name, input int spd, input int md, input int budget);
        int n = 0;
        while (!(bus.speed_o == spd && bus.mode_o == md) && n < budget) begin
            step();
            n++;
        end
        chk(name, int'(bus.speed_o == spd && bus.mode_o == md), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, inc, dec, zc, bad, nb, rise, mx, zeros, n;
        bit seen10;
        int seq[$];
        int exp_up[3] = '{50, 100, 120};
        int exp_dn[3] = '{70, 20, 0};
        bus.cmd_valid_i = 0; bus.cmd_mode_i = 0; bus.cmd_speed_i = 0; bus.estop_i = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset mode", bus.mode_o, 0);
        chk("reset speed", bus.speed_o, 0);
        chk("reset busy", bus.busy_o, 0);
        chk("reset at_target", bus.at_target_o, 1);
        chk("reset cmd_ready", bus.cmd_ready_o, 1);
        #10 rst_n = 1'b1;

        // forward ramp to 750
        cmd(2'b01, 10'd750);
        chk("t1 mode next cycle", bus.mode_o, 1);
        chk("t1 speed start", bus.speed_o, 0);
        inc = 0; prev = 0; n = 0;
        while (bus.speed_o != 750 && n < 100) begin
            step(); n++;
            if (bus.speed_o != prev) inc++;
            prev = bus.speed_o;
        end
        chk("t1 reached 750", bus.speed_o, 750);
        chk("t1 tick steps", inc, 15);
        chk("t1 at_target", bus.at_target_o, 1);
        chk("t1 busy", bus.busy_o, 0);

        // reversal: brake, dwell, ramp the other way
        prev = 750; dec = 0; zc = 0; bad = 0; nb = 0; rise = 0; seen10 = 0; n = 0;
        cmd(2'b10, 10'd600);
        while (!(bus.mode_o == 2 && bus.speed_o == 600) && n < 300) begin
            if (bus.mode_o == 0) zc++;
            if (bus.mode_o == 2) seen10 = 1;
            if (!seen10 && bus.speed_o > 0 && bus.mode_o != 1) bad++;
            if (seen10 && bus.speed_o != 600) rise++;
            if (bus.speed_o < prev) dec++;
            if (!bus.busy_o) nb++;
            prev = bus.speed_o;
            step(); n++;
        end
        chk("t2 reached 10/600", int'(bus.mode_o == 2 && bus.speed_o == 600), 1);
        chk("t2 brake steps", dec, 15);
        chk("t2 dwell cycles", zc, DT * TD);
        chk("t2 mode held while braking", bad, 0);
        chk("t2 climb cycles", rise, 12 * TD);
        chk("t2 not-busy cycles", nb, 0);

        // short ramp up and stop
        cmd(2'b00, 10'd0);
        wait_for("t3 idle", 0, 0, 120);
        cmd(2'b01, 10'd120);
        seq.delete(); prev = 0; n = 0;
        while (bus.speed_o != 120 && n < 60) begin
            step(); n++;
            if (bus.speed_o != prev) begin seq.push_back(bus.speed_o); prev = bus.speed_o; end
        end
        chk("t3 up count", seq.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t3 up[%0d]", i), i < seq.size() ? seq[i] : -1, exp_up[i]);
        cmd(2'b00, 10'd500);
        seq.delete(); n = 0;
        while (n < 60) begin
            if (bus.speed_o != prev) begin seq.push_back(bus.speed_o); prev = bus.speed_o; end
            if (bus.speed_o == 0) break;
            step(); n++;
        end
        chk("t3 down count", seq.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t3 down[%0d]", i), i < seq.size() ? seq[i] : -1, exp_dn[i]);
        chk("t3 mode at zero", bus.mode_o, 0);
        chk("t3 at_target", bus.at_target_o, 1);

        // clamp to MAX_SPEED, then restore direction mid-brake
        cmd(2'b01, 10'd1023);
        mx = 0; n = 0;
        while (bus.speed_o != 1000 && n < 120) begin
            if (bus.speed_o > mx) mx = bus.speed_o;
            step(); n++;
        end
        repeat (12) begin
            if (bus.speed_o > mx) mx = bus.speed_o;
            step();
        end
        chk("t4 max speed", mx, 1000);
        chk("t4 held at 1000", bus.speed_o, 1000);
        chk("t4 at_target", bus.at_target_o, 1);
        cmd(2'b10, 10'd500);
        repeat (10) step();
        chk("t4 brake keeps mode", bus.mode_o, 1);
        chk("t4 brake slowing", int'(bus.speed_o < 1000), 1);
        chk("t4 brake busy", bus.busy_o, 1);
        cmd(2'b01, 10'd400);
        chk("t4 restored mode", bus.mode_o, 1);
        bad = 0; n = 0;
        while (bus.speed_o != 400 && n < 100) begin
            step(); n++;
            if (bus.mode_o != 1) bad++;
        end
        chk("t4 reached 400", bus.speed_o, 400);
        chk("t4 mode stayed 01", bad, 0);

        // estop mid-ramp
        cmd(2'b00, 10'd0);
        wait_for("t5 idle", 0, 0, 80);
        cmd(2'b01, 10'd800);
        wait_for("t5 at 300", 300, 1, 60);
        @(negedge clk);
        bus.estop_i = 1; bus.cmd_valid_i = 1; bus.cmd_mode_i = 2'b10; bus.cmd_speed_i = 10'd900;
        step();
        chk("t5 estop speed", bus.speed_o, 0);
        chk("t5 estop mode", bus.mode_o, 0);
        chk("t5 estop ready", bus.cmd_ready_o, 0);
        repeat (3) step();
        chk("t5 estop held mode", bus.mode_o, 0);
        @(negedge clk);
        bus.estop_i = 0; bus.cmd_valid_i = 0;
        #1 chk("t5 ready before edge", bus.cmd_ready_o, 0);
        step();
        chk("t5 ready after release", bus.cmd_ready_o, 1);
        repeat (8) step();
        chk("t5 ignored cmd mode", bus.mode_o, 0);
        chk("t5 ignored cmd speed", bus.speed_o, 0);
        chk("t5 busy", bus.busy_o, 0);

        // asynchronous reset mid-ramp
        cmd(2'b01, 10'd800);
        wait_for("t6 at 200", 200, 1, 60);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6 async mode", bus.mode_o, 0);
        chk("t6 async speed", bus.speed_o, 0);
        chk("t6 async at_target", bus.at_target_o, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cmd(2'b01, 10'd100);
        chk("t6 mode", bus.mode_o, 1);
        zeros = 1; n = 0;
        while (bus.speed_o == 0 && n < 20) begin
            step(); n++;
            if (bus.speed_o == 0) zeros++;
        end
        chk("t6 fresh tick phase", zeros, 3);
        chk("t6 first step", bus.speed_o, 50);
        wait_for("t6 reached 100", 100, 1, 20);
        chk("t6 at_target", bus.at_target_o, 1);

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Motion controller that sits between command sources (switch decoder, line-tracker FSM) and the `motor` driver block.
- Produces the `mode[1:0]`/`speed[9:0]` pair the `motor` block consumes.
- Ramps speed toward a commanded target at a fixed rate and forces ramp-to-zero plus a dwell before any direction change, protecting the H-bridge.
- Emergency stop bypasses the ramp.

Parameters:
- TICK_DIV, 100000: clk cycles per ramp tick (min 1).
- STEP, 10'd25: speed change per tick (min 1).
- DWELL_TICKS, 50: ticks held at mode 00 / speed 0 between opposing directions (min 1).
- MAX_SPEED, 10'd1000: clamp applied to accepted cmd_speed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command strobe
- cmd_mode  in  2  requested mode: 00 stop, 01 forward, 10 backward, 11 spin
- cmd_speed  in  10  requested target speed
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- estop  in  1  level emergency stop
- mode  out  2  to motor.mode
- speed  out  10  to motor.speed
- busy  out  1  state is BRAKE or DWELL, or speed != target
- at_target  out  1  speed == target and mode == active requested mode

Behaviour:
- Reset (rst=0, async): mode=00, speed=0, target=0, state IDLE, tick counter=0, dwell counter=0, busy=0, at_target=1, cmd_ready=1.
- Tick generator: free-running counter 0..TICK_DIV-1; tick is a 1-cycle pulse when count==TICK_DIV-1. The counter is not reset by commands.
- Command acceptance:
  - Accepted on any cycle with cmd_valid=1 and cmd_ready=1.
  - cmd_ready=0 only in ESTOP or while estop=1.
  - cmd_speed is clamped to MAX_SPEED.
  - cmd_mode=00 or clamped speed 0 is a stop request (req_mode=00, target=0).
  - A later command fully replaces the pending req_mode/target.
- States:
  - IDLE: mode=00, speed=0. On a non-stop command: req_mode==mode is impossible here, so mode<=req_mode next cycle and go to RUN.
  - RUN: mode=active mode. On each tick, speed moves toward target by STEP with a saturating step: up = min(speed+STEP, target), down = max(speed-STEP, target), computed 11 bits wide with no wrap. Transitions:
    - Stop request: ramp down; when speed reaches 0, mode<=00 and go to IDLE.
    - Command whose non-00 req_mode differs from mode while speed>0: go to BRAKE.
    - Same mode: retarget only, no state change.
  - BRAKE: mode held at the old direction, speed ramps down STEP per tick to 0. At speed==0, mode<=00, dwell counter cleared, go to DWELL. A command restoring the old mode returns to RUN at once, ramping to the new target.
  - DWELL: mode=00, speed=0. Counts ticks; after DWELL_TICKS ticks, mode<=req_mode and go to RUN. A stop request during DWELL goes to IDLE. Other commands update req_mode/target without restarting the count.
- estop=1 (any state, highest priority):
  - Next cycle: speed=0, mode=00, target=0, state ESTOP, cmd_ready=0; no ramp.
  - A cmd_valid in the same cycle as estop is not accepted.
  - estop falling: next cycle state IDLE, cmd_ready=1.
- Outputs are registered; a command accepted at cycle N is visible on mode no earlier than N+1. Speed changes occur only on the cycle after a tick, except on estop.
- Reset mid-ramp: outputs return to their reset values immediately (async); no tick residue.

Test Plan:
Bench parameters: TICK_DIV=4, STEP=50, DWELL_TICKS=2, MAX_SPEED=1000.
1. Reset, then cmd 01/750 -> mode=01 next cycle; speed climbs 50 per tick (every 4 clk); reaches 750 after 15 ticks; at_target=1, busy=0.
2. At 01/750, cmd 10/600 -> mode stays 01 while speed falls to 0 over 15 ticks; mode=00 for 2 ticks; then mode=10 and speed climbs to 600 in 12 ticks; busy=1 throughout the sequence.
3. From IDLE, cmd 01/120 -> speed sequence 50, 100, 120; then cmd 00/x -> 70, 20, 0; mode=00 and IDLE on the cycle speed reaches 0.
4. cmd 01/1023 -> target clamped to 1000; speed saturates at 1000 and never exceeds it. During BRAKE (01 to 10), cmd 01/400 -> immediate RUN, speed ramps toward 400 with mode=01.
5. estop pulse mid-ramp at speed 300 -> next cycle speed=0, mode=00, cmd_ready=0; a cmd_valid during estop is ignored; after release, IDLE with cmd_ready=1.
6. rst low asynchronously mid-ramp (between clk edges) -> mode=00, speed=0 immediately; after release, a cmd 01/100 ramps from 0.
